icache_refill_responder: RTL and testbench

- Memory-side read responder for the icache refill bus; it is the other end of the cache's ar/r channel.
- Accepts one line-refill read request at a time, carrying a 1-bit length (0 = 1 beat, 1 = 2 beats).
- Fetches each 64-bit beat from a one-cycle-latency synchronous memory port after programmable wait states.
- Returns the beats with resp/last, honouring r_ready backpressure; used as the bench and SoC-side memory model behind the icache.

---
 rtl/icache_refill_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_icache_refill_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_responder.sv
// ---------------------------------------------------------------------------
// icache_refill_responder
//
// Memory-side read responder for the icache refill bus. It accepts one
// line-refill request at a time (1 or 2 beats of DATA_WIDTH), reads every
// beat from a one-cycle-latency synchronous memory port and returns the beats
// with resp/last under r_ready backpressure. Requests outside the legal
// window [MEM_BASE, MEM_BASE+MEM_SIZE) are answered with SLVERR beats
// without ever touching memory.
//
// Optional build macro: ICACHE_RSP_RAND_DELAY_EN
//   When defined, an 8-bit LFSR adds 0..3 extra wait cycles to every
//   entry into WAIT. When undefined, timing is fully deterministic.
//
// Ports
//   clk          clock
//   rst          synchronous, active-high reset
//   ar_valid_i   request valid
//   ar_ready_o   request ready (registered)
//   ar_addr_i    request byte address (bits [2:0] ignored)
//   ar_len_i     beats minus one
//   r_valid_o    beat valid (registered)
//   r_ready_i    beat accepted
//   r_resp_o     2'b00 OKAY, 2'b10 SLVERR
//   r_data_o     beat data
//   r_last_o     final beat of the burst
//   mem_en_o     memory read strobe, one cycle per beat
//   mem_addr_o   8-byte aligned memory read address (held when idle)
//   mem_rdata_i  memory read data, valid the cycle after mem_en_o
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request
// WAIT  | counting wait states; strobes memory when the counter is zero
// READ  | memory data arrives this cycle, captured into the beat register
// RESP  | beat presented on r_*, waiting for r_ready_i
// ---------------------------------------------------------------------------
module icache_refill_responder #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h8000_0000,
    parameter logic [ADDR_WIDTH-1:0] MEM_SIZE   = 32'h0800_0000,
    parameter int                    LATENCY    = 2,
    parameter int                    CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic                  ar_len_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [1:0]            r_resp_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic                  r_last_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  LAT_CNT = CNT_WIDTH'(LATENCY);
    // One extra bit so MEM_BASE+MEM_SIZE cannot wrap at the top of the map.
    localparam logic [ADDR_WIDTH:0]   WIN_LO  = {1'b0, MEM_BASE};
    localparam logic [ADDR_WIDTH:0]   WIN_HI  = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [1:0]              beats;
    logic [CNT_WIDTH-1:0]    cnt;
    logic                    err;

    logic                    ar_hs;
    logic                    r_hs;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    req_legal;
    logic [CNT_WIDTH-1:0]    cnt_first;
    logic [CNT_WIDTH-1:0]    cnt_next;
    logic                    unused_addr_lsb;

    assign ar_hs     = ar_valid_i & ar_ready_o;
    assign r_hs      = r_valid_o & r_ready_i;
    assign req_addr  = {ar_addr_i[ADDR_WIDTH-1:3], 3'b000};
    assign req_legal = ({1'b0, req_addr} >= WIN_LO) && ({1'b0, req_addr} < WIN_HI);
    assign unused_addr_lsb = ^ar_addr_i[2:0];

`ifdef ICACHE_RSP_RAND_DELAY_EN
    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, free-running from reset.
    logic [7:0] lfsr;
    logic       lfsr_fb;

    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    assign cnt_first = LAT_CNT + {{(CNT_WIDTH-2){1'b0}}, lfsr[1:0]};
    assign cnt_next  = {{(CNT_WIDTH-2){1'b0}}, lfsr[1:0]};
`else
    assign cnt_first = LAT_CNT;
    assign cnt_next  = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ar_hs) begin
                    state_nxt = req_legal ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (r_hs) begin
                    if (r_last_o) begin
                        state_nxt = IDLE;
                    end else if (err) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the memory strobe is combinational so it lands exactly in
    // the cycle the wait counter reaches zero; the address port otherwise
    // shows the last address actually strobed.
    always_comb begin
        mem_en_o   = (state == WAIT) && (cnt == '0);
        mem_addr_o = mem_en_o ? addr : mem_addr_q;
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_ready_o <= 1'b0;
            r_valid_o  <= 1'b0;
            r_resp_o   <= 2'b00;
            r_data_o   <= '0;
            r_last_o   <= 1'b0;
            addr       <= '0;
            mem_addr_q <= '0;
            beats      <= 2'd0;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        ar_ready_o <= 1'b0;
                        addr       <= req_addr;
                        beats      <= ar_len_i ? 2'd2 : 2'd1;
                        if (req_legal) begin
                            cnt <= cnt_first;
                        end else begin
                            err       <= 1'b1;
                            r_data_o  <= '0;
                            r_resp_o  <= 2'b10;
                            r_valid_o <= 1'b1;
                            r_last_o  <= ~ar_len_i;
                        end
                    end else begin
                        ar_ready_o <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        mem_addr_q <= addr;
                    end
                end
                READ: begin
                    r_data_o  <= mem_rdata_i;
                    r_resp_o  <= 2'b00;
                    r_last_o  <= (beats == 2'd1);
                    r_valid_o <= 1'b1;
                end
                RESP: begin
                    if (r_hs) begin
                        if (r_last_o) begin
                            r_valid_o  <= 1'b0;
                            r_last_o   <= 1'b0;
                            ar_ready_o <= 1'b1;
                            err        <= 1'b0;
                        end else begin
                            beats   <= beats - 2'd1;
                            // Second beat wraps within the 16-byte line.
                            addr[3] <= ~addr[3];
                            if (err) begin
                                r_last_o <= 1'b1;
                            end else begin
                                r_valid_o <= 1'b0;
                                cnt       <= cnt_next;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_responder.sv
module tb_icache_refill_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid;
    logic        ar_ready_o;
    logic [31:0] ar_addr;
    logic        ar_len;
    logic        r_valid_o;
    logic        r_ready;
    logic [1:0]  r_resp_o;
    logic [63:0] r_data_o;
    logic        r_last_o;
    logic        mem_en_o;
    logic [31:0] mem_addr_o;
    logic [63:0] mem_rdata = '0;

    icache_refill_responder #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (32),
        .MEM_BASE   (32'h8000_0000),
        .MEM_SIZE   (32'h0800_0000),
        .LATENCY    (LAT),
        .CNT_WIDTH  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ar_valid_i  (ar_valid),
        .ar_ready_o  (ar_ready_o),
        .ar_addr_i   (ar_addr),
        .ar_len_i    (ar_len),
        .r_valid_o   (r_valid_o),
        .r_ready_i   (r_ready),
        .r_resp_o    (r_resp_o),
        .r_data_o    (r_data_o),
        .r_last_o    (r_last_o),
        .mem_en_o    (mem_en_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: returns its own address as data one cycle later.
    always @(posedge clk) if (mem_en_o) mem_rdata <= {32'h0, mem_addr_o};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8800_0000);
    endfunction

    // Event logs filled by the compare process.
    int          bq_c[$];
    logic [63:0] bq_d[$];
    logic        bq_l[$];
    logic [1:0]  bq_r[$];
    int          mq_c[$];
    logic [31:0] mq_a[$];

    // Transaction-level model: beats pending, next beat due cycle, line address.
    int          m_pend = 0;
    bit          m_err = 0;
    logic [31:0] m_addr = '0;
    int          m_due = 0;
    int          m_rdy_from = 32'h3fff_ffff;
    logic [31:0] m_mem_last = '0;

    always @(negedge clk) begin
        bit er, ev, em;
        er = (m_pend == 0) && (cyc >= m_rdy_from);
        ev = (m_pend > 0) && (cyc >= m_due);
        em = (m_pend > 0) && !m_err && (cyc == m_due - 2);
        chk("ar_ready", 64'(ar_ready_o), 64'(er));
        chk("r_valid", 64'(r_valid_o), 64'(ev));
        if (ev) begin
            chk("r_data", r_data_o, m_err ? 64'h0 : {32'h0, m_addr});
            chk("r_resp", 64'(r_resp_o), m_err ? 64'h2 : 64'h0);
            chk("r_last", 64'(r_last_o), 64'(m_pend == 1));
        end
        chk("mem_en", 64'(mem_en_o), 64'(em));
        chk("mem_addr", 64'(mem_addr_o), 64'(em ? m_addr : m_mem_last));

        if (r_valid_o && r_ready) begin
            bq_c.push_back(cyc); bq_d.push_back(r_data_o);
            bq_l.push_back(r_last_o); bq_r.push_back(r_resp_o);
        end
        if (mem_en_o) begin
            mq_c.push_back(cyc); mq_a.push_back(mem_addr_o);
        end

        if (rst) begin
            m_pend = 0; m_err = 0; m_mem_last = '0; m_rdy_from = cyc + 2;
        end else begin
            if (em) m_mem_last = m_addr;
            if (ev && r_ready) begin
                m_pend--;
                m_addr[3] = ~m_addr[3];
                m_due = m_err ? cyc + 1 : cyc + 3;
                if (m_pend == 0) m_rdy_from = cyc + 1;
            end else if (er && ar_valid) begin
                m_addr = {ar_addr[31:3], 3'b000};
                m_pend = ar_len ? 2 : 1;
                m_err  = !legal(m_addr);
                m_due  = m_err ? cyc + 1 : cyc + 3 + LAT;
            end
        end
    end

    task automatic clear_logs();
        bq_c.delete(); bq_d.delete(); bq_l.delete(); bq_r.delete();
        mq_c.delete(); mq_a.delete();
    endtask

    task automatic do_req(input logic [31:0] a, input logic len, output int t);
        @(posedge clk); #1;
        ar_valid = 1'b1; ar_addr = a; ar_len = len;
        t = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ar_ready_o) begin t = cyc; break; end
        end
        if (t < 0) chk("ar_handshake_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (bq_c.size() >= n) begin done = 1; break; end
        end
        if (!done) chk("beat_timeout", 64'(bq_c.size()), 64'(n));
    endtask

    task automatic chk_beat(input string n, input int i, input int c, input logic [63:0] d,
                            input logic l, input logic [1:0] r);
        if (bq_c.size() > i) begin
            chk({n, "_cyc"}, 64'(bq_c[i]), 64'(c));
            chk({n, "_data"}, bq_d[i], d);
            chk({n, "_last"}, 64'(bq_l[i]), 64'(l));
            chk({n, "_resp"}, 64'(bq_r[i]), 64'(r));
        end else chk({n, "_missing"}, 64'(bq_c.size()), 64'(i + 1));
    endtask

    task automatic chk_mem(input string n, input int i, input int c, input logic [31:0] a);
        if (mq_c.size() > i) begin
            chk({n, "_cyc"}, 64'(mq_c[i]), 64'(c));
            chk({n, "_addr"}, 64'(mq_a[i]), 64'(a));
        end else chk({n, "_missing"}, 64'(mq_c.size()), 64'(i + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, v;
        rst = 1'b1; ar_valid = 1'b0; ar_addr = '0; ar_len = 1'b0; r_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ar_ready", 64'(ar_ready_o), 64'd0);
        chk("rst_r_valid", 64'(r_valid_o), 64'd0);
        chk("rst_r_data", r_data_o, 64'd0);
        chk("rst_r_resp_last", {r_resp_o, r_last_o}, 64'd0);
        chk("rst_mem", {mem_en_o, mem_addr_o}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("release_ar_ready", 64'(ar_ready_o), 64'd1);

        // Two-beat legal burst, no backpressure.
        clear_logs();
        do_req(32'h8000_0010, 1'b1, t);
        wait_beats(2);
        chk("t1_mem_count", 64'(mq_c.size()), 64'd2);
        chk_mem("t1_mem0", 0, t + 3, 32'h8000_0010);
        chk_mem("t1_mem1", 1, t + 6, 32'h8000_0018);
        chk_beat("t1_b0", 0, t + 5, 64'h8000_0010, 1'b0, 2'b00);
        chk_beat("t1_b1", 1, t + 8, 64'h8000_0018, 1'b1, 2'b00);
        repeat (3) @(posedge clk);

        // Backpressure on beat 0 for four cycles.
        clear_logs();
        #1 r_ready = 1'b0;
        do_req(32'h8000_0040, 1'b1, t);
        v = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (r_valid_o) begin v = cyc; break; end
        end
        chk("t2_first_valid", 64'(v), 64'(t + 5));
        repeat (4) @(posedge clk);
        #1 r_ready = 1'b1;
        wait_beats(2);
        chk_beat("t2_b0", 0, t + 9, 64'h8000_0040, 1'b0, 2'b00);
        chk_mem("t2_mem1", 1, t + 10, 32'h8000_0048);
        chk_beat("t2_b1", 1, t + 12, 64'h8000_0048, 1'b1, 2'b00);
        repeat (3) @(posedge clk);

        // Illegal address: two SLVERR beats, memory untouched.
        clear_logs();
        do_req(32'h0000_1000, 1'b1, t);
        wait_beats(2);
        chk("t3_mem_count", 64'(mq_c.size()), 64'd0);
        chk_beat("t3_b0", 0, t + 1, 64'h0, 1'b0, 2'b10);
        chk_beat("t3_b1", 1, t + 2, 64'h0, 1'b1, 2'b10);
        repeat (2) @(posedge clk);

        // Wrap within the line, low address bits ignored.
        clear_logs();
        do_req(32'h8000_002D, 1'b1, t);
        wait_beats(2);
        chk_mem("t4_mem0", 0, t + 3, 32'h8000_0028);
        chk_mem("t4_mem1", 1, t + 6, 32'h8000_0020);
        chk_beat("t4_b1", 1, t + 8, 64'h8000_0020, 1'b1, 2'b00);

        // Window boundaries: last legal beat and first illegal address.
        clear_logs();
        do_req(32'h87FF_FFF8, 1'b0, t);
        wait_beats(1);
        chk_beat("t5_top", 0, t + 5, 64'h87FF_FFF8, 1'b1, 2'b00);
        do_req(32'h8800_0000, 1'b0, t);
        wait_beats(2);
        chk_beat("t5_over", 1, t + 1, 64'h0, 1'b1, 2'b10);
        do_req(32'h7FFF_FFF8, 1'b0, t);
        wait_beats(3);
        chk_beat("t5_under", 2, t + 1, 64'h0, 1'b1, 2'b10);
        chk("t5_mem_count", 64'(mq_c.size()), 64'd1);
        repeat (2) @(posedge clk);

        // Reset during the wait of beat 1, then a fresh single-beat request.
        clear_logs();
        do_req(32'h8000_0080, 1'b1, t);
        wait_beats(1);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        chk("t6_no_more_beats", 64'(bq_c.size()), 64'd1);
        do_req(32'h8000_0100, 1'b0, t);
        wait_beats(2);
        chk_beat("t6_after", 1, t + 5, 64'h8000_0100, 1'b1, 2'b00);
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
